dvp_frame_tx: RTL and testbench

DVP_FRAME_TX -- requirements
Module: dvp_frame_tx

---
 rtl/dvp_pkg.sv | 28 ++
 rtl/dvp_frame_tx_if.sv | 23 ++
 rtl/dvp_line_timer.sv | 43 ++++
 rtl/dvp_frame_tx.sv | 134 +++++++++++++
 tb/tb_dvp_frame_tx.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/dvp_pkg.sv
// rtl/dvp_pkg.sv - shared FSM states, byte-order constant and timing helpers for the DVP transmitter
package dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } dvp_state_e;

  // RGB565 goes out high byte first: even h_cnt = pix[15:8], odd h_cnt = pix[7:0].
  localparam bit RGB565_MSB_FIRST = 1'b1;

  function automatic int line_len(input int hdisp, input int hblank);
    return 2 * hdisp + hblank;
  endfunction

  function automatic int frame_len(input int hdisp, input int hblank, input int vsync_lines,
                                   input int vbp_lines, input int vdisp, input int vfp_lines);
    return line_len(hdisp, hblank) * (vsync_lines + vbp_lines + vdisp + vfp_lines);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dvp_frame_tx_if.sv
// rtl/dvp_frame_tx_if.sv - upstream pixel handshake, DVP output bus and frame status signals
// master: the transmitter (drives pix_req, dvp_*, frame_*, busy); slave: its environment.
interface dvp_frame_tx_if;
  logic        enable;
  logic        pix_req;
  logic [15:0] pix_data;
  logic        dvp_vsync;
  logic        dvp_href;
  logic [7:0]  dvp_data;
  logic        frame_start;
  logic        frame_done;
  logic        busy;

  modport master (
    input  enable, pix_data,
    output pix_req, dvp_vsync, dvp_href, dvp_data, frame_start, frame_done, busy
  );

  modport slave (
    output enable, pix_data,
    input  pix_req, dvp_vsync, dvp_href, dvp_data, frame_start, frame_done, busy
  );
endinterface

// File: rtl/dvp_line_timer.sv
// rtl/dvp_line_timer.sv - horizontal counter with end-of-line strobe and href/pix_req phase decode
// Ports: clk, rst_n (async active-low), i_run (count while high, else hold 0),
//        o_sol/o_eol (first/last cycle of line), o_odd (low byte slot), o_href_ph (active byte slot),
//        o_req_in (pixel needed 2 cycles later in this line), o_req_early (first pixel of next line).
module dvp_line_timer
  import dvp_pkg::*;
#(
  parameter int HDISP  = 640,
  parameter int HBLANK = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_sol,
  output logic o_eol,
  output logic o_odd,
  output logic o_href_ph,
  output logic o_req_in,
  output logic o_req_early
);
  localparam int LINE_LEN = line_len(HDISP, HBLANK);
  localparam int HW       = $clog2(LINE_LEN);

  logic [HW-1:0] r_h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
    end else if (!i_run || o_eol) begin
      r_h <= '0;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  assign o_sol       = (r_h == '0);
  assign o_eol       = (int'(r_h) == LINE_LEN - 1);
  assign o_odd       = r_h[0];
  assign o_href_ph   = (int'(r_h) < 2 * HDISP);
  // Request lead of 2: one cycle for the output register, one for upstream latency.
  assign o_req_in    = !r_h[0] && (int'(r_h) + 2 < 2 * HDISP);
  assign o_req_early = (int'(r_h) == LINE_LEN - 2);
endmodule

// File: rtl/dvp_frame_tx.sv
// rtl/dvp_frame_tx.sv - DVP frame transmitter: RGB565 pixels out as an 8-bit vsync/href byte stream
// Ports: clk, rst_n (async active-low); bus (dvp_frame_tx_if.master): enable level, pix_req/pix_data
//        upstream fetch, dvp_vsync/dvp_href/dvp_data video, frame_start/frame_done/busy status.
module dvp_frame_tx
  import dvp_pkg::*;
#(
  parameter logic [9:0] IMG_HDISP   = 10'd640,
  parameter logic [9:0] IMG_VDISP   = 10'd480,
  parameter int         H_BLANK     = 16,
  parameter int         VSYNC_LINES = 4,
  parameter int         VBP_LINES   = 16,
  parameter int         VFP_LINES   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  dvp_frame_tx_if.master bus
);
  localparam int HDISP = int'(IMG_HDISP);
  localparam int VDISP = int'(IMG_VDISP);
  localparam int VMAX  = max_int(max_int(VSYNC_LINES, VBP_LINES), max_int(VDISP, VFP_LINES));
  localparam int VW    = $clog2(VMAX + 1);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_VSYNC  = ST_VSYNC;
  localparam logic [2:0] S_VBP    = ST_VBP;
  localparam logic [2:0] S_ACTIVE = ST_ACTIVE;
  localparam logic [2:0] S_VFP    = ST_VFP;

  logic [2:0]    r_state;
  logic [VW-1:0] r_v;
  logic [VW-1:0] w_lines_m1;
  logic          w_last_line;
  logic          w_sol, w_eol, w_odd, w_href_ph, w_req_in, w_req_early;
  logic          w_active;

  logic          r_vsync, r_href, r_req, r_fstart, r_fdone, r_busy;
  logic [7:0]    r_data;
  logic [15:0]   r_pix;

  dvp_line_timer #(
    .HDISP  (HDISP),
    .HBLANK (H_BLANK)
  ) u_line_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_run       (r_state != S_IDLE),
    .o_sol       (w_sol),
    .o_eol       (w_eol),
    .o_odd       (w_odd),
    .o_href_ph   (w_href_ph),
    .o_req_in    (w_req_in),
    .o_req_early (w_req_early)
  );

  always_comb begin
    w_lines_m1 = '0;
    case (r_state)
      S_VSYNC:  w_lines_m1 = VW'(VSYNC_LINES - 1);
      S_VBP:    w_lines_m1 = VW'(VBP_LINES - 1);
      S_ACTIVE: w_lines_m1 = VW'(VDISP - 1);
      S_VFP:    w_lines_m1 = VW'(VFP_LINES - 1);
      default:  w_lines_m1 = '0;
    endcase
  end

  assign w_last_line = (r_v == w_lines_m1);
  assign w_active    = (r_state == S_ACTIVE);

  // enable is only looked at in IDLE and on the final VFP cycle, so frames always run to completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_v     <= '0;
    end else if (r_state == S_IDLE) begin
      r_v <= '0;
      if (bus.enable) r_state <= S_VSYNC;
    end else if (w_eol) begin
      if (w_last_line) begin
        r_v <= '0;
        case (r_state)
          S_VSYNC:  r_state <= S_VBP;
          S_VBP:    r_state <= S_ACTIVE;
          S_ACTIVE: r_state <= S_VFP;
          S_VFP:    r_state <= bus.enable ? S_VSYNC : S_IDLE;
          default:  r_state <= S_IDLE;
        endcase
      end else begin
        r_v <= r_v + 1'b1;
      end
    end
  end

  // Counters lead the registered outputs by one cycle; every output is a decode of the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync  <= 1'b0;
      r_href   <= 1'b0;
      r_req    <= 1'b0;
      r_fstart <= 1'b0;
      r_fdone  <= 1'b0;
      r_busy   <= 1'b0;
      r_data   <= 8'h00;
      r_pix    <= 16'h0000;
    end else begin
      r_vsync  <= (r_state == S_VSYNC);
      r_busy   <= (r_state != S_IDLE);
      r_fstart <= (r_state == S_VSYNC) && (r_v == '0) && w_sol;
      r_fdone  <= (r_state == S_VFP) && w_last_line && w_eol;
      // The next line is active after the last VBP line and after every ACTIVE line but the last.
      r_req    <= (w_active && w_req_in) ||
                  (w_req_early && (((r_state == S_VBP) && w_last_line) || (w_active && !w_last_line)));
      r_href   <= w_active && w_href_ph;
      if (w_active && w_href_ph) begin
        if (!w_odd) begin
          // pix_data is valid now, one cycle after its request; hold it for the second byte.
          r_pix  <= bus.pix_data;
          r_data <= RGB565_MSB_FIRST ? bus.pix_data[15:8] : bus.pix_data[7:0];
        end else begin
          r_data <= RGB565_MSB_FIRST ? r_pix[7:0] : r_pix[15:8];
        end
      end else begin
        r_data <= 8'h00;
      end
    end
  end

  assign bus.dvp_vsync   = r_vsync;
  assign bus.dvp_href    = r_href;
  assign bus.dvp_data    = r_data;
  assign bus.pix_req     = r_req;
  assign bus.frame_start = r_fstart;
  assign bus.frame_done  = r_fdone;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_dvp_frame_tx.sv
// tb/tb_dvp_frame_tx.sv - randomized self-checking bench for dvp_frame_tx against a frame-timing model
module tb_dvp_frame_tx;
  localparam int HD   = 4;
  localparam int VD   = 2;
  localparam int HB   = 3;
  localparam int VS   = 1;
  localparam int VB   = 1;
  localparam int VF   = 1;
  localparam int LL   = 2 * HD + HB;
  localparam int FL   = LL * (VS + VB + VD + VF);
  localparam int NPIX = HD * VD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dvp_frame_tx_if bus ();

  dvp_frame_tx #(
    .IMG_HDISP   (10'd4),
    .IMG_VDISP   (10'd2),
    .H_BLANK     (HB),
    .VSYNC_LINES (VS),
    .VBP_LINES   (VB),
    .VFP_LINES   (VF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] src      [NPIX];
  logic [15:0] fixed_px [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
  int          src_idx  = 0;
  logic        req_q    = 1'b0;
  logic [15:0] cap_q    [$];
  logic [7:0]  cap_hi   = 8'h00;
  logic        cap_have = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: upstream source answers last cycle's pix_req, capture side rebuilds pixels from href bytes.
  task automatic tick();
    @(posedge clk);
    #1;
    if (req_q && src_idx < NPIX) begin
      bus.pix_data = src[src_idx];
      src_idx++;
    end else begin
      bus.pix_data = 16'($urandom);
    end
    req_q = bus.pix_req;
    if (bus.dvp_href === 1'b1) begin
      if (cap_have) begin
        cap_q.push_back({cap_hi, bus.dvp_data});
        cap_have = 1'b0;
      end else begin
        cap_hi   = bus.dvp_data;
        cap_have = 1'b1;
      end
    end else begin
      cap_have = 1'b0;
    end
  endtask

  task automatic wait_start(output bit ok);
    int waited = 0;
    while (bus.frame_start !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    ok = (bus.frame_start === 1'b1);
    check_val("frame_start_seen", 32'(ok), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"},  32'(bus.busy),      32'd0);
    check_val({tag, "_vsync"}, 32'(bus.dvp_vsync), 32'd0);
    check_val({tag, "_href"},  32'(bus.dvp_href),  32'd0);
    check_val({tag, "_req"},   32'(bus.pix_req),   32'd0);
    check_val({tag, "_data"},  32'(bus.dvp_data),  32'd0);
    check_val({tag, "_start"}, 32'(bus.frame_start), 32'd0);
    check_val({tag, "_done"},  32'(bus.frame_done),  32'd0);
  endtask

  // Checks one whole frame cycle by cycle from frame_start; drop_at >= 0 releases enable at that offset.
  task automatic run_frame(input bit fixed, input int drop_at);
    bit ok;
    wait_start(ok);
    if (!ok) return;
    for (int i = 0; i < NPIX; i++) src[i] = (fixed && i < 4) ? fixed_px[i] : 16'($urandom);
    src_idx = 0;
    cap_q.delete();
    cap_have = 1'b0;
    for (int o = 0; o < FL; o++) begin
      int          lin, h, o2, l2, h2, p;
      logic        act, e_href, e_req;
      logic [7:0]  e_data;
      logic [15:0] px;
      if (o > 0) tick();
      lin    = o / LL;
      h      = o % LL;
      act    = (lin >= VS + VB) && (lin < VS + VB + VD);
      e_href = act && (h < 2 * HD);
      e_data = 8'h00;
      if (e_href) begin
        p      = (lin - VS - VB) * HD + h / 2;
        px     = src[p];
        e_data = (h % 2 == 0) ? px[15:8] : px[7:0];
      end
      o2    = o + 2;
      l2    = o2 / LL;
      h2    = o2 % LL;
      e_req = (o2 < FL) && (l2 >= VS + VB) && (l2 < VS + VB + VD) && (h2 < 2 * HD) && (h2 % 2 == 0);
      check_val($sformatf("vsync@%0d", o), 32'(bus.dvp_vsync),   32'(lin < VS));
      check_val($sformatf("href@%0d", o),  32'(bus.dvp_href),    32'(e_href));
      check_val($sformatf("data@%0d", o),  32'(bus.dvp_data),    32'(e_data));
      check_val($sformatf("req@%0d", o),   32'(bus.pix_req),     32'(e_req));
      check_val($sformatf("start@%0d", o), 32'(bus.frame_start), 32'(o == 0));
      check_val($sformatf("done@%0d", o),  32'(bus.frame_done),  32'(o == FL - 1));
      check_val($sformatf("busy@%0d", o),  32'(bus.busy),        32'd1);
      if (o == drop_at) bus.enable = 1'b0;
    end
    check_val("cap_count", 32'(cap_q.size()), 32'(NPIX));
    for (int i = 0; i < NPIX && i < cap_q.size(); i++)
      check_val($sformatf("cap_px%0d", i), 32'(cap_q[i]), 32'(src[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    bus.enable   = 1'b0;
    bus.pix_data = 16'h0000;
    for (int i = 0; i < NPIX; i++) src[i] = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    tick();
    tick();
    check_idle("idle");

    // Single frame from a one-cycle enable pulse, fixed byte-order pixels first.
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    run_frame(1'b1, -1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_idle($sformatf("after_single%0d", i));
    end

    // Continuous frames back to back, last one with enable dropped during ACTIVE.
    bus.enable = 1'b1;
    run_frame(1'b0, -1);
    tick();
    check_val("cont_gap1", 32'(bus.frame_start), 32'd1);
    run_frame(1'b0, -1);
    tick();
    check_val("cont_gap2", 32'(bus.frame_start), 32'd1);
    run_frame(1'b0, 27);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_idle($sformatf("after_drop%0d", i));
    end

    // Asynchronous reset in the middle of an active line, then a clean full frame.
    bus.enable = 1'b1;
    wait_start(ok);
    if (ok) begin
      repeat (25) tick();
      check_val("pre_reset_href", 32'(bus.dvp_href), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("mid_reset");
      tick();
      check_idle("mid_reset_hold");
      rst_n    = 1'b1;
      req_q    = 1'b0;
      cap_have = 1'b0;
      run_frame(1'b0, 30);
      tick();
      check_idle("after_reset_frame");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
